// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enable simple-dual-port memory.
package mem_pkg;

    // Same-address read-during-write policy selectors.
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Clear sequencer states.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    // Number of byte lanes in a data word.
    function automatic int be_width(input int dat_width);
        return dat_width / 8;
    endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero,
// then hands the array over to the user ports.
module mem_init_seq
    import mem_pkg::*;
#(
    parameter int ADD_WIDTH  = 8,
    parameter int INIT_CLEAR = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_busy,
    output logic                 clr_we,
    output logic [ADD_WIDTH-1:0] clr_add,
    output clr_state_t           state
);

    clr_state_t           state_nxt;
    logic [ADD_WIDTH-1:0] cnt;

    // State register; reset restarts the clear (or skips it when disabled).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Address counter advances once per clear write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state and outputs; leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        init_busy = 1'b0;
        clr_we    = 1'b0;
        clr_add   = cnt;
        case (state)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                if (cnt == {ADD_WIDTH{1'b1}}) begin
                    state_nxt = ST_READY;
                end
            end
            default: begin
                state_nxt = ST_READY;
            end
        endcase
    end

endmodule

// File: rtl/mem_sdp_be.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle registered
// reads, selectable read-during-write policy and a post-reset clear.
// Handshake: a request is accepted on a rising edge when its enable is high
// and init_busy is low; rd_vld is a single-cycle pulse per accepted read,
// RD_LATENCY cycles after acceptance, with no backpressure.
module mem_sdp_be
    import mem_pkg::*;
#(
    parameter int ADD_WIDTH  = 8,
    parameter int DAT_WIDTH  = 32,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int INIT_CLEAR = 1,
    parameter int DELAY      = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADD_WIDTH-1:0]            wr_add,
    input  logic [DAT_WIDTH-1:0]            wr_dat,
    input  logic [be_width(DAT_WIDTH)-1:0]  wr_be,
    input  logic                            rd_en,
    input  logic [ADD_WIDTH-1:0]            rd_add,
    output logic [DAT_WIDTH-1:0]            rd_dat,
    output logic                            rd_vld,
    output logic                            init_busy
);

    localparam int DEPTH = 2 ** ADD_WIDTH;
    localparam int BE_W  = be_width(DAT_WIDTH);

    // Parameter legality; rd_dat is modelled with zero delay, DELAY must be non-negative.
    if (DAT_WIDTH % 8 != 0) begin : g_bad_width
        $error("mem_sdp_be: DAT_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("mem_sdp_be: RD_LATENCY must be 1 or 2");
    end
    if (DELAY < 0) begin : g_bad_delay
        $error("mem_sdp_be: DELAY must be non-negative");
    end

    logic [DAT_WIDTH-1:0] mem [DEPTH];

    logic                 clr_we;
    logic [ADD_WIDTH-1:0] clr_add;
    clr_state_t           clr_state;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [DAT_WIDTH-1:0] old_word;
    logic [DAT_WIDTH-1:0] merged_word;
    logic [DAT_WIDTH-1:0] rd_word;
    logic                 s1_vld;
    logic [DAT_WIDTH-1:0] s1_dat;

    mem_init_seq #(
        .ADD_WIDTH  (ADD_WIDTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_add   (clr_add),
        .state     (clr_state)
    );

    // User requests only count once the clear has finished.
    assign wr_acc = wr_en && (clr_state == ST_READY);
    assign rd_acc = rd_en && (clr_state == ST_READY);

    // Read word selection, including the write-first bypass merge.
    always_comb begin
        old_word    = mem[rd_add];
        merged_word = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
                merged_word[8*i +: 8] = wr_dat[8*i +: 8];
            end
        end
        rd_word = old_word;
        if (RDW_MODE == RDW_WRITE_FIRST && wr_acc && (wr_add == rd_add)) begin
            rd_word = merged_word;
        end
    end

    // Array write: the clear sequencer owns the port while it runs.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_add] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_add][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    // Read stage 1; data holds when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                 s2_vld;
        logic [DAT_WIDTH-1:0] s2_dat;

        // Extra output register stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat <= s1_dat;
                end
            end
        end

        assign rd_vld = s2_vld;
        assign rd_dat = s2_dat;
    end else begin : g_lat1
        assign rd_vld = s1_vld;
        assign rd_dat = s1_dat;
    end

endmodule

// File: tb/tb_mem_sdp_be.sv
// Scoreboard bench for mem_sdp_be: two instances (latency 1 / read-first and
// latency 2 / write-first) share one stimulus stream; each has its own
// expected-data and expected-cycle queues popped by a monitor.
module tb_mem_sdp_be;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_add = '0;
    logic [DW-1:0] wr_dat = '0;
    logic [BW-1:0] wr_be = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_add = '0;

    logic [DW-1:0] rd_dat_a, rd_dat_b;
    logic          rd_vld_a, rd_vld_b;
    logic          busy_a, busy_b;

    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    int            cyc_a_q[$];
    int            cyc_b_q[$];

    int cyc     = 0;
    int vec_cnt = 0;
    int err_cnt = 0;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sdp_be #(
        .ADD_WIDTH(AW), .DAT_WIDTH(DW), .RD_LATENCY(1),
        .RDW_MODE(0), .INIT_CLEAR(1), .DELAY(0)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_add(wr_add), .wr_dat(wr_dat),
        .wr_be(wr_be), .rd_en(rd_en), .rd_add(rd_add), .rd_dat(rd_dat_a),
        .rd_vld(rd_vld_a), .init_busy(busy_a)
    );

    mem_sdp_be #(
        .ADD_WIDTH(AW), .DAT_WIDTH(DW), .RD_LATENCY(2),
        .RDW_MODE(1), .INIT_CLEAR(1), .DELAY(0)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_add(wr_add), .wr_dat(wr_dat),
        .wr_be(wr_be), .rd_en(rd_en), .rd_add(rd_add), .rd_dat(rd_dat_b),
        .rd_vld(rd_vld_b), .init_busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance a.
    always @(negedge clk) begin : mon_a
        logic [DW-1:0] d;
        int            c;
        if (rd_vld_a === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_vld", {31'b0, rd_vld_a}, 32'd0);
            end else begin
                d = exp_a_q.pop_front();
                c = cyc_a_q.pop_front();
                check("a_rd_dat", rd_dat_a, d);
                check("a_rd_cycle", cyc, c);
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin : mon_b
        logic [DW-1:0] d;
        int            c;
        if (rd_vld_b === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_vld", {31'b0, rd_vld_b}, 32'd0);
            end else begin
                d = exp_b_q.pop_front();
                c = cyc_b_q.pop_front();
                check("b_rd_dat", rd_dat_b, d);
                check("b_rd_cycle", cyc, c);
            end
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        wr_en  = 1'b1;
        wr_add = a;
        wr_dat = d;
        wr_be  = be;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        rd_en  = 1'b1;
        rd_add = a;
        exp_a_q.push_back(ea);
        cyc_a_q.push_back(cyc + 1);
        exp_b_q.push_back(eb);
        cyc_b_q.push_back(cyc + 2);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            check("drain_timeout", exp_a_q.size() + exp_b_q.size(), 32'd0);
        end
    endtask

    initial begin : stim
        int busy_a_n;
        int busy_b_n;

        // Reset values.
        repeat (3) tick();
        check("rst_rd_vld_a", {31'b0, rd_vld_a}, 32'd0);
        check("rst_rd_vld_b", {31'b0, rd_vld_b}, 32'd0);
        check("rst_rd_dat_a", rd_dat_a, 32'd0);
        check("rst_rd_dat_b", rd_dat_b, 32'd0);
        check("rst_busy_a", {31'b0, busy_a}, 32'd1);
        check("rst_busy_b", {31'b0, busy_b}, 32'd1);

        // Reset at clear count 7 restarts the sequence.
        rst = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("midclr_busy_a", {31'b0, busy_a}, 32'd1);
        check("midclr_busy_b", {31'b0, busy_b}, 32'd1);
        tick();
        rst = 1'b0;

        // Count busy cycles; requests at busy cycle 3 must be dropped.
        busy_a_n = 0;
        busy_b_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy_a) busy_a_n++;
            if (busy_b) busy_b_n++;
            if (k == 3) begin
                do_write(4'd2, 32'h1234_5678, 4'hf);
                rd_en  = 1'b1;
                rd_add = 4'd2;
            end else begin
                idle();
            end
        end
        check("busy_cycles_a", busy_a_n, 32'd16);
        check("busy_cycles_b", busy_b_n, 32'd16);
        tick();

        // Every address reads zero after the clear, back to back.
        for (int a = 0; a < 16; a++) begin
            do_read(a[AW-1:0], 32'h0, 32'h0);
            tick();
        end
        idle();
        drain();

        // Byte-enable merge.
        do_write(4'd3, 32'hAABB_CCDD, 4'b1111);
        tick();
        do_write(4'd3, 32'h1122_3344, 4'b0101);
        tick();
        idle();
        do_read(4'd3, 32'hAA22_CC44, 32'hAA22_CC44);
        tick();
        idle();
        drain();

        // wr_be = 0 leaves the word untouched.
        do_write(4'd3, 32'hDEAD_BEEF, 4'b0000);
        tick();
        idle();
        do_read(4'd3, 32'hAA22_CC44, 32'hAA22_CC44);
        tick();
        idle();
        drain();

        // Latency and throughput with distinct data.
        do_write(4'd0, 32'hA0A0_0000, 4'hf);
        tick();
        do_write(4'd1, 32'hB1B1_1111, 4'hf);
        tick();
        do_write(4'd2, 32'hC2C2_2222, 4'hf);
        tick();
        idle();
        do_read(4'd0, 32'hA0A0_0000, 32'hA0A0_0000);
        tick();
        do_read(4'd1, 32'hB1B1_1111, 32'hB1B1_1111);
        tick();
        do_read(4'd2, 32'hC2C2_2222, 32'hC2C2_2222);
        tick();
        idle();
        drain();

        // Same-address read during write: read-first vs write-first.
        do_write(4'd5, 32'hFFFF_FFFF, 4'b0011);
        do_read(4'd5, 32'h0000_0000, 32'h0000_FFFF);
        tick();
        idle();
        do_read(4'd5, 32'h0000_FFFF, 32'h0000_FFFF);
        tick();
        idle();
        drain();

        // Different addresses do not interact.
        do_write(4'd6, 32'h5555_AAAA, 4'hf);
        do_read(4'd5, 32'h0000_FFFF, 32'h0000_FFFF);
        tick();
        idle();
        do_read(4'd6, 32'h5555_AAAA, 32'h5555_AAAA);
        tick();
        idle();
        drain();
        repeat (3) tick();
        check("hold_rd_dat_a", rd_dat_a, 32'h5555_AAAA);
        check("hold_rd_dat_b", rd_dat_b, 32'h5555_AAAA);

        // Reset with a read in flight: nothing may emerge.
        rd_en  = 1'b1;
        rd_add = 4'd6;
        tick();
        rst = 1'b1;
        idle();
        tick();
        check("inflight_vld_a", {31'b0, rd_vld_a}, 32'd0);
        check("inflight_vld_b", {31'b0, rd_vld_b}, 32'd0);
        check("inflight_dat_a", rd_dat_a, 32'd0);
        check("inflight_dat_b", rd_dat_b, 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("reclear_busy_a", {31'b0, busy_a}, 32'd0);
        check("reclear_busy_b", {31'b0, busy_b}, 32'd0);
        check("queues_empty", exp_a_q.size() + exp_b_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
